conv2d_stream: RTL and testbench

//  Streaming 3x3 2D convolution engine; parametrised successor to the fixed 8x8 array convolver.

---
 rtl/conv2d_pkg.sv | 28 ++
 rtl/conv2d_line_buffer.sv | 29 ++
 rtl/conv2d_stream.sv | 155 +++++++++++++++
 tb/tb_conv2d_stream.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
// Shared types, constants and helpers for the streaming 3x3 convolver.
package conv2d_pkg;

  localparam int KIDX_W = 4;
  localparam int KTAPS  = 9;

  // Row-major 1/16 Gaussian loaded into both kernel banks on reset.
  localparam int GAUSS_DEFAULT [KTAPS] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

  // Kernel at the default 8-bit coefficient width.
  typedef logic signed [7:0] kernel_t [KTAPS];

  function automatic int sum_w(input int data_w, input int coef_w);
    return data_w + coef_w + 4;
  endfunction

  // With sat set, clamp v into a signed w-bit range; otherwise leave it for the caller to truncate.
  function automatic longint resize_out(input longint v, input int w, input bit sat);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (sat && v > hi) return hi;
    if (sat && v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv2d_line_buffer.sv
// One-row circular delay: dout is the sample written DEPTH shifts earlier.
module conv2d_line_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (reset)         ptr <= '0;
    else if (shift_en) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  end

  // Contents are not cleared; the row counter decides when they are meaningful.
  always_ff @(posedge clk) begin
    if (shift_en) mem[ptr] <= din;
  end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming 3x3 convolver: raster pixels in, one result per interior pixel out.
// Build option CONV2D_SATURATE_EN clamps the result to OUT_W; otherwise it wraps.
module conv2d_stream
  import conv2d_pkg::*;
#(
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int FRAC_BITS = 4,
  parameter int OUT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              k_we,
  input  logic [KIDX_W-1:0] k_addr,
  input  logic [COEF_W-1:0] k_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy
);
  localparam int PW     = DATA_W + COEF_W;
  localparam int SUM_W  = sum_w(DATA_W, COEF_W);
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int STAGES = 3;
`ifdef CONV2D_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic                     adv, accept, frame_start, win_ok, win_last;
  logic [STAGES:0]          vld_pipe, last_pipe;
  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic signed [COEF_W-1:0] k_shadow [KTAPS];
  logic signed [COEF_W-1:0] k_act    [KTAPS];
  logic [DATA_W-1:0]        lb_in    [2];
  logic [DATA_W-1:0]        lb_out   [2];
  logic signed [DATA_W-1:0] win      [KTAPS];
  logic signed [PW-1:0]     prod     [KTAPS];
  logic signed [SUM_W-1:0]  acc, sum_q, shifted;
  logic [OUT_W-1:0]         out_d, out_q;
  logic                     busy_q;

  // The whole pipeline moves in lockstep whenever the output slot can take a result.
  assign adv         = !vld_pipe[STAGES] || out_ready;
  assign in_ready    = adv && !reset;
  assign accept      = in_valid && in_ready;
  assign frame_start = accept && col == '0 && row == '0;
  assign win_ok      = row >= RW'(2) && col >= CW'(2);
  assign win_last    = row == RW'(IMG_H - 1) && col == CW'(IMG_W - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Active bank is only refreshed at frame start, so a frame sees one kernel throughout.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < KTAPS; i++) begin
        k_shadow[i] <= COEF_W'(GAUSS_DEFAULT[i]);
        k_act[i]    <= COEF_W'(GAUSS_DEFAULT[i]);
      end
    end else begin
      if (k_we && k_addr < KIDX_W'(KTAPS)) k_shadow[k_addr] <= k_data;
      if (frame_start) k_act <= k_shadow;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_lb
    if (g == 0) begin : g_head
      assign lb_in[g] = in_data;
    end else begin : g_tail
      assign lb_in[g] = lb_out[g-1];
    end
    conv2d_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb (
      .clk      (clk),
      .reset    (reset),
      .shift_en (accept),
      .din      (lb_in[g]),
      .dout     (lb_out[g])
    );
  end

  // Window taps row-major; the new column is {two rows up, one row up, current}.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r*3]   <= win[r*3+1];
        win[r*3+1] <= win[r*3+2];
      end
      win[2] <= lb_out[1];
      win[5] <= lb_out[0];
      win[8] <= in_data;
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < KTAPS; i++)
      acc = acc + {{(SUM_W-PW){prod[i][PW-1]}}, prod[i]};
  end

  assign shifted = sum_q >>> FRAC_BITS;
  assign out_d   = OUT_W'(resize_out(longint'(shifted), OUT_W, SAT_EN));

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int i = 0; i < KTAPS; i++) prod[i] <= PW'(win[i]) * PW'(k_act[i]);
      sum_q <= acc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      out_q     <= '0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], accept && win_ok};
      last_pipe <= {last_pipe[STAGES-1:0], accept && win_ok && win_last};
      out_q     <= out_d;
    end
  end

  // A new frame's first pixel may land on the same edge the previous last result leaves.
  always_ff @(posedge clk) begin
    if (reset)                                          busy_q <= 1'b0;
    else if (accept)                                    busy_q <= 1'b1;
    else if (vld_pipe[STAGES] && out_ready && last_pipe[STAGES]) busy_q <= 1'b0;
  end

  assign out_valid = vld_pipe[STAGES] && !reset;
  assign out_last  = last_pipe[STAGES] && !reset;
  assign out_data  = reset ? '0 : out_q;
  assign busy      = busy_q && !reset;

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed self-checking bench for conv2d_stream (16-bit and 8-bit result builds).
module tb_conv2d_stream;

`ifdef CONV2D_SATURATE_EN
  localparam int EXP8 = 127;
`else
  localparam int EXP8 = 112;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        iv, ir, kwe, ov, ordy, ol, busy;
  logic [7:0]  id, kdata;
  logic [3:0]  kaddr;
  logic [15:0] od;
  logic        iv8, ir8, kwe8, ov8, ordy8, ol8, busy8;
  logic [7:0]  id8, kdata8, od8;
  logic [3:0]  kaddr8;

  int ncmp = 0;
  int nfail = 0;
  int bp_err = 0;
  int qd[$];
  bit ql[$];
  int qd8[$];
  bit ql8[$];

  always #5 clk = ~clk;

  conv2d_stream #(.IMG_W(8), .IMG_H(8), .DATA_W(8), .COEF_W(8), .FRAC_BITS(4), .OUT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .in_data(id),
    .k_we(kwe), .k_addr(kaddr), .k_data(kdata),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .out_last(ol), .busy(busy));

  conv2d_stream #(.IMG_W(8), .IMG_H(8), .DATA_W(8), .COEF_W(8), .FRAC_BITS(4), .OUT_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .k_we(kwe8), .k_addr(kaddr8), .k_data(kdata8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_last(ol8), .busy(busy8));

  always @(negedge clk) begin
    if (ov && ordy) begin
      qd.push_back(int'($signed(od)));
      ql.push_back(ol);
    end
    if (ov && !ordy && ir) bp_err++;
    if (ov8 && ordy8) begin
      qd8.push_back(int'($signed(od8)));
      ql8.push_back(ol8);
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic kwrite(input bit sel, input int a, input int d);
    if (sel) begin kwe8 = 1'b1; kaddr8 = 4'(a); kdata8 = 8'(d); end
    else     begin kwe  = 1'b1; kaddr  = 4'(a); kdata  = 8'(d); end
    @(posedge clk); #1;
    kwe = 1'b0; kwe8 = 1'b0;
  endtask

  task automatic send_px(input bit sel, input logic [7:0] d, input bit rnd);
    int  n = 0;
    bit  got = 1'b0;
    if (sel) begin iv8 = 1'b1; id8 = d; end
    else     begin iv  = 1'b1; id  = d; end
    while (!got && n < 200) begin
      ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      got = sel ? ir8 : ir;
      @(posedge clk); #1;
      n++;
    end
    iv = 1'b0; iv8 = 1'b0;
    chk("px_accept", got, 1);
  endtask

  task automatic run_frame(input bit sel, input int mode, input bit rnd, input int kw_idx);
    for (int p = 0; p < 64; p++) begin
      int r = p / 8;
      int c = p % 8;
      logic [7:0] d;
      d = (mode == 0) ? 8'd16 : (mode == 1) ? 8'(r * 8 + c) : 8'd127;
      if (p == kw_idx) begin kwe = 1'b1; kaddr = 4'd4; kdata = 8'd32; end
      send_px(sel, d, rnd);
      kwe = 1'b0;
    end
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    bit b = 1'b1;
    while (b && n < 400) begin
      ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      b = busy || busy8;
      @(posedge clk); #1;
      n++;
    end
    ordy = 1'b1;
    chk("drain_busy", b, 0);
  endtask

  // mode 0: constant 16; mode 1: window centre (r*8+c) times scale; mode 2: 8-bit build constant.
  task automatic check_frame(input bit sel, input int mode, input int scale, input string tag);
    int sz = sel ? qd8.size() : qd.size();
    chk({tag, "_count"}, sz, 36);
    for (int i = 0; i < 36; i++) begin
      if (i < sz) begin
        int rr = 1 + i / 6;
        int cc = 1 + i % 6;
        int e  = (mode == 0) ? 16 : (mode == 1) ? (rr * 8 + cc) * scale : EXP8;
        chk({tag, "_data"}, sel ? qd8[i] : qd[i], e);
        chk({tag, "_last"}, sel ? ql8[i] : ql[i], (i == 35) ? 1 : 0);
      end
    end
    qd.delete(); ql.delete(); qd8.delete(); ql8.delete();
  endtask

  initial begin
    reset = 1'b1;
    iv = 0; id = 0; kwe = 0; kaddr = 0; kdata = 0; ordy = 1;
    iv8 = 0; id8 = 0; kwe8 = 0; kaddr8 = 0; kdata8 = 0; ordy8 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", ir, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_out_data", od, 0);
    chk("rst_out_last", ol, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", ir, 1);
    @(posedge clk); #1;

    // Default Gaussian on a flat frame.
    run_frame(0, 0, 0, -1);
    drain(0);
    check_frame(0, 0, 1, "gauss_flat");

    // Identity kernel on a ramp.
    for (int i = 0; i < 9; i++) kwrite(0, i, (i == 4) ? 16 : 0);
    run_frame(0, 1, 0, -1);
    drain(0);
    check_frame(0, 1, 1, "ident_ramp");

    // Same frame under random backpressure.
    bp_err = 0;
    run_frame(0, 1, 1, -1);
    drain(1);
    check_frame(0, 1, 1, "ident_bp");
    chk("bp_in_ready", bp_err, 0);

    // Mid-frame shadow write only takes effect on the next frame.
    run_frame(0, 1, 0, 30);
    drain(0);
    check_frame(0, 1, 1, "midwrite_cur");
    run_frame(0, 1, 0, -1);
    drain(0);
    check_frame(0, 1, 2, "midwrite_next");

    // 8-bit result build: saturate or wrap.
    for (int i = 0; i < 9; i++) kwrite(1, i, 127);
    run_frame(1, 2, 0, -1);
    drain(0);
    check_frame(1, 2, 1, "out8");

    // Reset part-way through a frame.
    for (int p = 0; p < 20; p++) send_px(0, 8'(p), 0);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_out_valid", ov, 0);
      chk("midrst_in_ready", ir, 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    qd.delete(); ql.delete(); qd8.delete(); ql8.delete();
    run_frame(0, 1, 0, -1);
    drain(0);
    check_frame(0, 1, 1, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
